window_avg_consumer: RTL and testbench

//  Downstream consumer of the 3-input minimum stage. Receives one 8-bit minimum per
//  dav_/rfd handshake and collects a window of N = 2**LOG2N samples.
//  At the end of each window it publishes the truncated mean and the peak of the window.

---
 rtl/window_avg_consumer_pkg.sv | 24 ++
 rtl/window_avg_consumer_win_acc.sv | 74 +++++++
 rtl/window_avg_consumer.sv | 132 +++++++++++++
 tb/tb_window_avg_consumer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/window_avg_consumer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : window_avg_consumer_pkg
//  Description : Shared definitions for the windowed average/peak consumer:
//                sample width and the four-state handshake FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package window_avg_consumer_pkg;

  localparam int DATA_W = 8;

  // S_IDLE : ready for an upstream sample (rfd=1)
  // S_ACK  : sample captured, waiting for upstream to release dav_
  // S_PUT  : result published, waiting for downstream to take it
  // S_REL  : waiting for downstream to become ready again
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_PUT  = 2'd2,
    S_REL  = 2'd3
  } state_e;

endpackage : window_avg_consumer_pkg
`default_nettype wire

// File: rtl/window_avg_consumer_win_acc.sv
`default_nettype none
// ============================================================================
//  Module      : win_acc
//  Description : Window accumulator. Holds the exact running sum, the running
//                maximum and the sample count for one window of 2**LOG2N
//                samples.
//  Ports       : clock   - system clock
//                reset_  - synchronous active-low reset
//                clr     - clear sum, max and count
//                add     - accumulate sample x (ignored while clr is high)
//                x       - unsigned sample
//                last    - count has reached the window length
//                mean    - floor(sum / N)
//                pk      - running maximum
//  Revision    : 1.0 - initial release
// ============================================================================
module win_acc
  import window_avg_consumer_pkg::*;
#(
  parameter int LOG2N = 2
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic              clr,
  input  logic              add,
  input  logic [DATA_W-1:0] x,
  output logic              last,
  output logic [DATA_W-1:0] mean,
  output logic [DATA_W-1:0] pk
);

  localparam int ACC_W = DATA_W + LOG2N;
  localparam int CNT_W = LOG2N + 1;
  localparam int N     = 1 << LOG2N;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] pk_q,  pk_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    pk_d  = pk_q;
    cnt_d = cnt_q;
    if (clr) begin
      acc_d = '0;
      pk_d  = '0;
      cnt_d = '0;
    end else if (add) begin
      acc_d = acc_q + ACC_W'(x);
      pk_d  = (x > pk_q) ? x : pk_q;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      acc_q <= '0;
      pk_q  <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      pk_q  <= pk_d;
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(N));
  // Dropping the low LOG2N bits is the truncating divide by N; the sum of
  // N 8-bit samples always fits, so the upper slice is exactly 8 bits.
  assign mean = acc_q[ACC_W-1:LOG2N];
  assign pk   = pk_q;

endmodule : win_acc
`default_nettype wire

// File: rtl/window_avg_consumer.sv
`default_nettype none
// ============================================================================
//  Module      : window_avg_consumer
//  Description : Consumes one 8-bit sample per dav_/rfd handshake, collects a
//                window of 2**LOG2N samples and publishes the truncated mean
//                and peak over a dav_out_/rfd_out handshake.
//  Ports       : clock    - system clock
//                reset_   - synchronous active-low reset
//                x        - upstream sample, valid while dav_ = 0
//                dav_     - upstream data available (active low)
//                rfd      - ready for data to upstream
//                avg      - floor(window sum / N)
//                peak     - window maximum
//                dav_out_ - downstream data available (active low)
//                rfd_out  - downstream ready for data
//  Revision    : 1.0 - initial release
// ============================================================================
module window_avg_consumer
  import window_avg_consumer_pkg::*;
#(
  parameter int LOG2N = 2
) (
  input  logic              clock,
  input  logic              reset_,
  input  logic [DATA_W-1:0] x,
  input  logic              dav_,
  output logic              rfd,
  output logic [DATA_W-1:0] avg,
  output logic [DATA_W-1:0] peak,
  output logic              dav_out_,
  input  logic              rfd_out
);

  state_e            state_q, state_d;
  logic              rfd_q, rfd_d;
  logic              dav_out_q, dav_out_d;
  logic [DATA_W-1:0] avg_q, avg_d;
  logic [DATA_W-1:0] peak_q, peak_d;

  logic              acc_clr;
  logic              acc_add;
  logic              acc_last;
  logic [DATA_W-1:0] acc_mean;
  logic [DATA_W-1:0] acc_pk;

  win_acc #(
    .LOG2N (LOG2N)
  ) u_win_acc (
    .clock  (clock),
    .reset_ (reset_),
    .clr    (acc_clr),
    .add    (acc_add),
    .x      (x),
    .last   (acc_last),
    .mean   (acc_mean),
    .pk     (acc_pk)
  );

  always_comb begin
    state_d   = state_q;
    rfd_d     = rfd_q;
    dav_out_d = dav_out_q;
    avg_d     = avg_q;
    peak_d    = peak_q;
    acc_clr   = 1'b0;
    acc_add   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!dav_) begin
          acc_add = 1'b1;
          rfd_d   = 1'b0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        // The count already includes the sample captured on entry here.
        if (dav_) begin
          if (acc_last) begin
            avg_d     = acc_mean;
            peak_d    = acc_pk;
            dav_out_d = 1'b0;
            state_d   = S_PUT;
          end else begin
            rfd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_PUT: begin
        if (!rfd_out) begin
          dav_out_d = 1'b1;
          state_d   = S_REL;
        end
      end
      S_REL: begin
        // rfd stays low until here: upstream is held off while a result
        // is outstanding.
        if (rfd_out) begin
          acc_clr = 1'b1;
          rfd_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state_q   <= S_IDLE;
      rfd_q     <= 1'b1;
      dav_out_q <= 1'b1;
      avg_q     <= '0;
      peak_q    <= '0;
    end else begin
      state_q   <= state_d;
      rfd_q     <= rfd_d;
      dav_out_q <= dav_out_d;
      avg_q     <= avg_d;
      peak_q    <= peak_d;
    end
  end

  assign rfd      = rfd_q;
  assign dav_out_ = dav_out_q;
  assign avg      = avg_q;
  assign peak     = peak_q;

endmodule : window_avg_consumer
`default_nettype wire

// File: tb/tb_window_avg_consumer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_avg_consumer
//  Description : Directed bench for window_avg_consumer with LOG2N=2 (dut_a)
//                and LOG2N=0 (dut_b).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_avg_consumer;

  logic       clock = 1'b0;
  logic       reset_;

  logic [7:0] a_x;
  logic       a_dav_;
  logic       a_rfd;
  logic [7:0] a_avg;
  logic [7:0] a_peak;
  logic       a_dav_out_;
  logic       a_rfd_out;

  logic [7:0] b_x;
  logic       b_dav_;
  logic       b_rfd;
  logic [7:0] b_avg;
  logic [7:0] b_peak;
  logic       b_dav_out_;
  logic       b_rfd_out;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  window_avg_consumer #(.LOG2N(2)) dut_a (
    .clock    (clock),
    .reset_   (reset_),
    .x        (a_x),
    .dav_     (a_dav_),
    .rfd      (a_rfd),
    .avg      (a_avg),
    .peak     (a_peak),
    .dav_out_ (a_dav_out_),
    .rfd_out  (a_rfd_out)
  );

  window_avg_consumer #(.LOG2N(0)) dut_b (
    .clock    (clock),
    .reset_   (reset_),
    .x        (b_x),
    .dav_     (b_dav_),
    .rfd      (b_rfd),
    .avg      (b_avg),
    .peak     (b_peak),
    .dav_out_ (b_dav_out_),
    .rfd_out  (b_rfd_out)
  );

  task automatic check_val(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full upstream handshake on dut_a; for the window's last sample also
  // checks that dav_out_ falls exactly one clock after dav_ rises.
  task automatic a_send(input logic [7:0] v, input bit last);
    for (int i = 0; i < 50 && !a_rfd; i++) tick();
    check_val("a_rfd_ready", 16'(a_rfd), 16'd1);
    a_x    = v;
    a_dav_ = 1'b0;
    tick();
    check_val("a_rfd_cap", 16'(a_rfd), 16'd0);
    a_dav_ = 1'b1;
    a_x    = 8'hxx;
    tick();
    if (last) begin
      check_val("a_dav_out_lat", 16'(a_dav_out_), 16'd0);
    end else begin
      check_val("a_rfd_back", 16'(a_rfd), 16'd1);
    end
  endtask

  // Downstream handshake on dut_a; rfd must return one clock after rfd_out rises.
  task automatic a_recv(input logic [7:0] e_avg, input logic [7:0] e_peak);
    for (int i = 0; i < 50 && a_dav_out_; i++) tick();
    check_val("a_dav_out_pub", 16'(a_dav_out_), 16'd0);
    check_val("a_avg", 16'(a_avg), 16'(e_avg));
    check_val("a_peak", 16'(a_peak), 16'(e_peak));
    a_rfd_out = 1'b0;
    tick();
    check_val("a_dav_out_rel", 16'(a_dav_out_), 16'd1);
    check_val("a_rfd_held", 16'(a_rfd), 16'd0);
    a_rfd_out = 1'b1;
    tick();
    check_val("a_rfd_resume", 16'(a_rfd), 16'd1);
  endtask

  initial begin
    logic [7:0] bvals [2];
    bvals[0] = 8'd42;
    bvals[1] = 8'd17;

    reset_    = 1'b0;
    a_x       = 8'd0;
    a_dav_    = 1'b1;
    a_rfd_out = 1'b1;
    b_x       = 8'd0;
    b_dav_    = 1'b1;
    b_rfd_out = 1'b1;

    // Reset: two clocks low
    tick();
    tick();
    check_val("rst_rfd", 16'(a_rfd), 16'd1);
    check_val("rst_dav_out", 16'(a_dav_out_), 16'd1);
    check_val("rst_avg", 16'(a_avg), 16'd0);
    check_val("rst_peak", 16'(a_peak), 16'd0);
    check_val("rst_b_rfd", 16'(b_rfd), 16'd1);
    check_val("rst_b_dav_out", 16'(b_dav_out_), 16'd1);
    reset_ = 1'b1;
    tick();

    // 10,20,30,40 -> sum 100, avg 25, peak 40
    a_send(8'd10, 1'b0);
    a_send(8'd20, 1'b0);
    a_send(8'd30, 1'b0);
    a_send(8'd40, 1'b1);
    a_recv(8'd25, 8'd40);

    // 255 x4 -> sum 1020, avg 255; previous result must hold meanwhile
    a_send(8'd255, 1'b0);
    check_val("hold_avg", 16'(a_avg), 16'd25);
    check_val("hold_peak", 16'(a_peak), 16'd40);
    a_send(8'd255, 1'b0);
    a_send(8'd255, 1'b0);
    a_send(8'd255, 1'b1);
    a_recv(8'd255, 8'd255);

    // 3,3,3,4 -> sum 13, avg 3 (truncated), peak 4; then downstream stall
    a_send(8'd3, 1'b0);
    a_send(8'd3, 1'b0);
    a_send(8'd3, 1'b0);
    a_send(8'd4, 1'b1);
    for (int k = 0; k < 10; k++) begin
      a_x    = 8'd200;
      a_dav_ = (k % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check_val("stall_dav_out", 16'(a_dav_out_), 16'd0);
      check_val("stall_rfd", 16'(a_rfd), 16'd0);
      check_val("stall_avg", 16'(a_avg), 16'd3);
      check_val("stall_peak", 16'(a_peak), 16'd4);
    end
    a_dav_ = 1'b1;
    a_recv(8'd3, 8'd4);

    // Partial window 7,9 aborted by reset, then 1,2,3,6 -> avg 3, peak 6
    a_send(8'd7, 1'b0);
    a_send(8'd9, 1'b0);
    reset_ = 1'b0;
    tick();
    tick();
    check_val("mid_rst_rfd", 16'(a_rfd), 16'd1);
    check_val("mid_rst_avg", 16'(a_avg), 16'd0);
    check_val("mid_rst_peak", 16'(a_peak), 16'd0);
    reset_ = 1'b1;
    tick();
    a_send(8'd1, 1'b0);
    a_send(8'd2, 1'b0);
    a_send(8'd3, 1'b0);
    a_send(8'd6, 1'b1);
    a_recv(8'd3, 8'd6);

    // LOG2N=0: every sample is published directly
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 50 && !b_rfd; i++) tick();
      check_val("b_rfd_ready", 16'(b_rfd), 16'd1);
      b_x    = bvals[j];
      b_dav_ = 1'b0;
      tick();
      b_dav_ = 1'b1;
      tick();
      check_val("b_dav_out_pub", 16'(b_dav_out_), 16'd0);
      check_val("b_avg", 16'(b_avg), 16'(bvals[j]));
      check_val("b_peak", 16'(b_peak), 16'(bvals[j]));
      b_rfd_out = 1'b0;
      tick();
      check_val("b_dav_out_rel", 16'(b_dav_out_), 16'd1);
      b_rfd_out = 1'b1;
      tick();
      check_val("b_rfd_resume", 16'(b_rfd), 16'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule : tb_window_avg_consumer
`default_nettype wire
